// File: rtl/change_dispenser.sv
// change_dispenser: turns a two-digit BCD change value into timed greedy
// eject pulses on the 10/5/1 coin hoppers, tracking the remaining change.
module change_dispenser #(
  parameter int PULSE_CYC = 50000,
  parameter int GAP_CYC   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] change_sw,
  input  logic [3:0] change_gw,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       coin10,
  output logic       coin5,
  output logic       coin1,
  output logic [3:0] rem_sw,
  output logic [3:0] rem_gw
);
  typedef enum logic [2:0] {IDLE, SEL, PULSE, GAP, DONE} state_t;
  localparam logic [19:0] PULSE_LOAD = 20'(PULSE_CYC - 1);
  localparam logic [19:0] GAP_LOAD   = 20'(GAP_CYC - 1);
  state_t      state_q, state_d;
  logic [6:0]  rem_q, rem_d;
  logic [19:0] tmr_q, tmr_d;
  logic [2:0]  coin_q, coin_d;
  logic [3:0]  rsw_q, rsw_d, rgw_q, rgw_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        valid;
  logic [6:0]  coin_val;
  assign valid    = (change_sw <= 4'd9) && (change_gw <= 4'd9);
  assign coin_val = coin_q[2] ? 7'd10 : coin_q[1] ? 7'd5 : 7'd1;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    coin_d  = coin_q;
    rsw_d   = rsw_q;
    rgw_d   = rgw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && valid) begin
          rem_d   = {3'b0, change_sw} * 7'd10 + {3'b0, change_gw};
          rsw_d   = change_sw;
          rgw_d   = change_gw;
          busy_d  = 1'b1;
          state_d = SEL;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      SEL: begin
        if (rem_q == 7'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          coin_d  = rem_q >= 7'd10 ? 3'b100 : rem_q >= 7'd5 ? 3'b010 : 3'b001;
          tmr_d   = PULSE_LOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (tmr_q == 20'd0) begin
          // greedy order means a 5 is only taken with tens=0 and ones>=5, so BCD needs no borrow
          coin_d  = 3'b000;
          rem_d   = rem_q - coin_val;
          rsw_d   = coin_q[2] ? rsw_q - 4'd1 : rsw_q;
          rgw_d   = coin_q[1] ? rgw_q - 4'd5 : coin_q[0] ? rgw_q - 4'd1 : rgw_q;
          tmr_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q - 20'd1;
        end
      end
      GAP: begin
        state_d = tmr_q == 20'd0 ? SEL : GAP;
        tmr_d   = tmr_q == 20'd0 ? tmr_q : tmr_q - 20'd1;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tmr_q   <= '0;
      coin_q  <= '0;
      rsw_q   <= '0;
      rgw_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      coin_q  <= coin_d;
      rsw_q   <= rsw_d;
      rgw_q   <= rgw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign coin10 = coin_q[2];
  assign coin5  = coin_q[1];
  assign coin1  = coin_q[0];
  assign rem_sw = rsw_q;
  assign rem_gw = rgw_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven checks of coin counts, pulse timing,
// remaining-change trace and err/done/busy, plus a mid-dispense reset sequence.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] change_sw = 4'd0;
  logic [3:0] change_gw = 4'd0;
  logic       busy, done, err, coin10, coin5, coin1;
  logic [3:0] rem_sw, rem_gw;
  int n_chk = 0;
  int n_fail = 0;

  change_dispenser #(.PULSE_CYC(2), .GAP_CYC(3)) dut (
    .clk(clk), .rst(rst), .start(start), .change_sw(change_sw), .change_gw(change_gw),
    .busy(busy), .done(done), .err(err), .coin10(coin10), .coin5(coin5), .coin1(coin1),
    .rem_sw(rem_sw), .rem_gw(rem_gw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] gw;
    int n10;
    int n5;
    int n1;
    int done_at;
    bit is_err;
    int repulse;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int greedy(input int v);
    return v >= 10 ? 10 : v >= 5 ? 5 : 1;
  endfunction

  task automatic run(input int idx, input vec_t v);
    int n10 = 0, n5 = 0, n1 = 0, done_at = -1, err_cnt = 0, busy_hi = 0;
    int first_rise = -1, bad = 0, hi_len = 0, exp_v;
    logic [2:0] p = 3'b000;
    logic [2:0] cv;
    bit valid;
    string tag;
    tag = $sformatf("v%0d", idx);
    valid = (v.sw <= 4'd9) && (v.gw <= 4'd9);
    exp_v = valid ? int'(v.sw) * 10 + int'(v.gw) : 0;
    @(negedge clk);
    change_sw = v.sw;
    change_gw = v.gw;
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 300; c++) begin
      if (c > 0) @(posedge clk);
      #1 start = 1'b0;
      cv = {coin10, coin5, coin1};
      if ($countones(cv) > 1) bad++;
      if (cv != 3'b000 && p == 3'b000) begin
        if (first_rise < 0) first_rise = c;
        n10 += int'(cv[2]);
        n5  += int'(cv[1]);
        n1  += int'(cv[0]);
      end
      if (cv != 3'b000) hi_len++;
      if (cv == 3'b000 && p != 3'b000) begin
        if (hi_len != 2) bad++;
        hi_len = 0;
        exp_v -= greedy(exp_v);
      end
      if (rem_sw != 4'(exp_v / 10) || rem_gw != 4'(exp_v % 10)) bad++;
      if (done) begin
        if (done_at < 0) done_at = c;
        else bad++;
      end
      err_cnt += int'(err);
      busy_hi += int'(busy);
      p = cv;
      if (c > 0 && c == v.repulse) begin
        start = 1'b1;
        change_sw = 4'd9;
        change_gw = 4'd9;
      end
      if (c >= 2 && !busy && !start) break;
    end
    check({tag, " coin10 count"}, n10, v.n10);
    check({tag, " coin5 count"}, n5, v.n5);
    check({tag, " coin1 count"}, n1, v.n1);
    check({tag, " done cycle"}, done_at, v.done_at);
    check({tag, " err cycles"}, err_cnt, v.is_err ? 1 : 0);
    check({tag, " busy cycles"}, busy_hi, v.is_err ? 0 : v.done_at + 1);
    check({tag, " first coin cycle"}, first_rise, (v.n10 + v.n5 + v.n1) > 0 ? 1 : -1);
    check({tag, " width/onehot/rem trace errors"}, bad, 0);
    check({tag, " final rem"}, int'({rem_sw, rem_gw}), 0);
  endtask

  initial begin
    tv[0] = '{4'd3, 4'd7, 3, 1, 2, 37, 1'b0, 0};
    tv[1] = '{4'd0, 4'd0, 0, 0, 0, 1, 1'b0, 0};
    tv[2] = '{4'hf, 4'hf, 0, 0, 0, -1, 1'b1, 0};
    tv[3] = '{4'd1, 4'hc, 0, 0, 0, -1, 1'b1, 0};
    tv[4] = '{4'd9, 4'd9, 9, 1, 4, 85, 1'b0, 0};
    tv[5] = '{4'd3, 4'd7, 3, 1, 2, 37, 1'b0, 7};
    tv[6] = '{4'd1, 4'd5, 1, 1, 0, 13, 1'b0, 0};
    tv[7] = '{4'd0, 4'd9, 0, 1, 4, 31, 1'b0, 0};
    tv[8] = '{4'ha, 4'd0, 0, 0, 0, -1, 1'b1, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done/err", int'({done, err}), 0);
    check("reset coins", int'({coin10, coin5, coin1}), 0);
    check("reset rem", int'({rem_sw, rem_gw}), 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) run(i, tv[i]);
    @(negedge clk);
    change_sw = 4'd2;
    change_gw = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    check("pre-reset coin10", int'(coin10), 1);
    check("pre-reset busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset coins", int'({coin10, coin5, coin1}), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset rem", int'({rem_sw, rem_gw}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset idle", int'({busy, done, err, coin10, coin5, coin1}), 0);
    run(9, '{4'd0, 4'd5, 0, 1, 0, 7, 1'b0, 0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-eject controller for the vending datapath, on the output side of the payment chain. The coin-acceptor/pricing logic accepts coins and computes change as a two-digit BCD value. This block turns that value into timed eject pulses on three coin-hopper outputs (10, 5, 1), using a greedy fewest-coins order. It reports progress through busy/done/err and a live remaining-change BCD pair for the 7-segment path.

## Interface
Parameters:
- PULSE_CYC, default 50000: eject pulse width in clk cycles (1 ms at 50 MHz); legal range 1..2^20-1.
- GAP_CYC, default 100000: low time after each pulse in clk cycles; legal range 1..2^20-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to dispense; sampled only in IDLE.
- change_sw  in  4  BCD tens digit of change; 4'hf = insufficient payment.
- change_gw  in  4  BCD ones digit of change; 4'hf = insufficient payment.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when dispensing completes.
- err  out  1  one-cycle pulse when start is rejected.
- coin10  out  1  eject pulse, 10-unit hopper.
- coin5  out  1  eject pulse, 5-unit hopper.
- coin1  out  1  eject pulse, 1-unit hopper.
- rem_sw  out  4  BCD tens digit of change not yet dispensed.
- rem_gw  out  4  BCD ones digit of change not yet dispensed.

## Operation
- States: IDLE, SEL, PULSE, GAP, DONE.
- Reset: state = IDLE. busy, done, err, coin10, coin5, coin1 = 0. rem_sw = rem_gw = 0. The internal 7-bit remainder and the 20-bit timer = 0.
- Reset mid-operation aborts immediately. Undispensed change is discarded and any active coin output drops asynchronously.

IDLE:
- start=1 and either digit > 9 (including 4'hf): err=1 for one cycle, stay in IDLE, busy stays 0.
- start=1 and both digits valid:
  - load remainder = 10*change_sw + change_gw (0..99);
  - load rem_sw/rem_gw from the inputs;
  - set busy=1 and go to SEL.

SEL (one cycle):
- remainder == 0: go to DONE.
- otherwise latch a coin in greedy order and go to PULSE:
  - remainder >= 10: coin 10;
  - else remainder >= 5: coin 5;
  - else coin 1.

PULSE:
- The selected coin output is high for exactly PULSE_CYC cycles; the other two stay low.
- On exit, subtract the coin value from the remainder, update rem_sw/rem_gw to match, and go to GAP.

GAP:
- All coin outputs low for GAP_CYC cycles, then go to SEL.

DONE (one cycle):
- done=1, busy stays 1; next state IDLE, where busy=0.

Other rules:
- start outside IDLE is ignored, with no effect on state or outputs.
- At most one coin output is high at any time.
- Coin outputs are driven directly from registers, never from combinational logic.
- Inputs change_sw/change_gw are read only at start acceptance; later changes have no effect.

## Timing
- Reference point: start accepted at clock edge E0, which enters SEL with busy=1.
- Coin k (k = 1..N):
  - selected in SEL at edge E0 + (k-1)*T, where T = 1 + PULSE_CYC + GAP_CYC;
  - its coin output is high from edge E0 + (k-1)*T + 1 for PULSE_CYC cycles.
- rem_sw/rem_gw update on the PULSE-to-GAP edge of each coin.
- done is high for the cycle after edge E0 + N*T + 1 (SEL finds 0, then DONE).
- busy falls at edge E0 + N*T + 2.
- Zero change (N=0): DONE at E0+1, busy falls at E0+2.
- err is high for the single cycle after the edge on which start was sampled.
- Greedy coin count for value V: N = V/10 + (V%10)/5 + V%5. Maximum is V=99: N=14.

## Test plan
All scenarios use PULSE_CYC=2, GAP_CYC=3 (T=6).
- Change 3,7 -> exactly 3 coin10, then 1 coin5, then 2 coin1 pulses, each 2 cycles high; rem goes 27,17,07,02,01,00; done 37 cycles after start.
- Change 0,0 -> no coin pulses; done 1 cycle after SEL; busy high for 2 cycles.
- Change f,f, and separately 1,12 -> err one cycle; busy, coins and rem stay 0.
- Change 9,9 -> 9 coin10, 1 coin5, 4 coin1 (14 pulses); done at E0+85.
- Change 3,7 with start re-pulsed (change 9,9) during the 2nd coin10 -> pulse sequence and rem identical to scenario 1.
- Change 2,0, rst asserted mid first coin10 pulse -> coin10 drops at once, all outputs 0. Then change 0,5 -> single coin5, done at E0+7.
